instruction_fetch_queue: RTL and testbench
==========================================

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 10: instruction-memory word address width.
REQ-002 Parameter DATA_WIDTH, default 32: instruction width.
REQ-003 Parameter IPC, default 4: instructions per fetch group.
REQ-004 Parameter FQ_DEPTH, default 4 (power of 2, >=2): queue capacity in groups.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 IM_address  output  ADDRESS_WIDTH  word address of the group's first instruction.
REQ-008 IM_readEnable  output  1  read request, one cycle wide per group.
REQ-009 IM_data  input  IPC*DATA_WIDTH  fetched group; slot i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 IM_dataValid  input  1  IM_data valid; always exactly 1 cycle after IM_readEnable.
REQ-011 DEC_data  output  IPC*DATA_WIDTH  queue head group to decode, same slot packing.
REQ-012 DEC_dataValid  output  1  DEC_data holds a valid group.
REQ-013 DEC_pc  output  ADDRESS_WIDTH  word address of head group slot 0.
REQ-014 DEC_ready  input  1  decode accepts the head group this cycle.
REQ-015 redirect  input  1  flush and restart fetching at redirectPC.
REQ-016 redirectPC  input  ADDRESS_WIDTH  restart word address.

Function
REQ-017 Fetch PC advances by IPC per issued request, wrapping modulo 2^ADDRESS_WIDTH.
REQ-018 IM_address and IM_readEnable are registered outputs.
REQ-019 Request issued only when occupancy + in-flight count < FQ_DEPTH (credit rule); a pop in the same cycle does not return credit until the following cycle.
REQ-020 FSM states: BOOT, FETCH, STALL, FLUSH.
REQ-021 BOOT: entered on reset; one cycle later -> FETCH; no request issued in BOOT.
REQ-022 FETCH: issue request each cycle credit allows; no credit -> STALL.
REQ-023 STALL: no request; credit available -> FETCH (issue in that same cycle).
REQ-024 redirect=1 in any state except BOOT -> FLUSH; queue emptied, fetch PC := redirectPC, DEC_dataValid=0 next cycle.
REQ-025 FLUSH: lasts exactly one cycle; any IM_dataValid arriving in this cycle is discarded; -> FETCH; first post-redirect request issues with IM_address=redirectPC.
REQ-026 redirect during FLUSH restarts FLUSH with the new redirectPC (last redirect wins).
REQ-027 redirect during BOOT is latched; BOOT exits to FLUSH instead of FETCH.
REQ-028 redirect has priority over push and pop in the same cycle; the popped group is still consumed by decode.
REQ-029 IM_dataValid outside FLUSH pushes IM_data with its request address into the tail.
REQ-030 DEC_dataValid = queue not empty; pop when DEC_dataValid && DEC_ready.
REQ-031 DEC_data/DEC_pc stable while DEC_dataValid=1 and DEC_ready=0.
REQ-032 Latency: IM_readEnable at cycle t -> IM_dataValid t+1 -> DEC_dataValid t+2 (empty queue).
REQ-033 Simultaneous push and pop: occupancy unchanged, head advances, no data loss.
REQ-034 Overflow impossible by REQ-019; push at full is an assertion failure.
REQ-035 Read/write pointers are log2(FQ_DEPTH)+1 bits, wrap naturally; full/empty derived from the MSB.

Reset
REQ-036 rst=0 asynchronously: state=BOOT, fetch PC=0, pointers=0, in-flight=0.
REQ-037 Outputs during/after reset: IM_readEnable=0, IM_address=0, DEC_dataValid=0, DEC_data=0, DEC_pc=0.
REQ-038 Reset mid-operation discards queued and in-flight groups; first post-reset request is address 0.

Structure
REQ-039 Shared package holds FSM state encoding and the default widths ADDRESS_WIDTH, DATA_WIDTH, IPC.
REQ-040 One sub-module: fetch_fifo (parameterised width/depth storage and pointers); FSM, PC and credit logic live in the top.

Verification
REQ-041 Reset, DEC_ready=1, IM echoes data=address: requests at addresses 0,4,8,...; DEC_pc 0,4,8 at cycles 3,4,5 after reset release.
REQ-042 DEC_ready=0 for 10 cycles: exactly 4 requests issued (addresses 0,4,8,12), then IM_readEnable=0; head DEC_pc=0 held stable.
REQ-043 redirect with redirectPC=0x100 while 3 groups queued and 1 in flight: next cycle DEC_dataValid=0, in-flight response dropped, next IM_address=0x100, next delivered DEC_pc=0x100.
REQ-044 Fetch PC reaches 0x3FC: next IM_address=0x000 (wrap).
REQ-045 DEC_ready toggling every cycle for 200 cycles: delivered DEC_pc sequence strictly +4, no gaps, no duplicates, never overflows.
REQ-046 rst asserted while queue full: outputs zero immediately (before next edge); after release, behaviour matches REQ-041.

Source files
------------

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: default widths and the
// fetch FSM state encoding.
package instruction_fetch_queue_pkg;

  localparam int unsigned DefaultAddressWidth = 10;
  localparam int unsigned DefaultDataWidth    = 32;
  localparam int unsigned DefaultIpc          = 4;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StFetch = 2'd1,
    StStall = 2'd2,
    StFlush = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch group storage: power-of-2 circular buffer with one extra pointer bit so
// full and empty are told apart by the MSB.
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [PtrW-1:0]  count
);

  localparam int unsigned IdxW = PtrW - 1;

  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                   (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]);
  // Clear wins over both push and pop.
  assign do_push = push && !clear;
  assign do_pop  = pop && !clear && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[IdxW-1:0]] <= push_data;
  end

  assign head_data = mem_q[rptr_q[IdxW-1:0]];
  assign count     = wptr_q - rptr_q;

  push_at_full_a: assert property (@(posedge clk) disable iff (!rst) !(do_push && full));

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: credit-limited group fetch from instruction memory
// into a small FIFO feeding decode, with redirect/flush support.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DefaultAddressWidth,
  parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
  parameter int unsigned IPC           = DefaultIpc,
  parameter int unsigned FQ_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [ADDRESS_WIDTH-1:0]      IM_address,
  output logic                          IM_readEnable,
  input  logic [IPC*DATA_WIDTH-1:0]     IM_data,
  input  logic                          IM_dataValid,
  output logic [IPC*DATA_WIDTH-1:0]     DEC_data,
  output logic                          DEC_dataValid,
  output logic [ADDRESS_WIDTH-1:0]      DEC_pc,
  input  logic                          DEC_ready,
  input  logic                          redirect,
  input  logic [ADDRESS_WIDTH-1:0]      redirectPC
);

  localparam int unsigned GroupW = IPC * DATA_WIDTH;
  localparam int unsigned EntryW = ADDRESS_WIDTH + GroupW;
  localparam int unsigned CntW   = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned SumW   = CntW + 1;

  fetch_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d, rsp_addr_q;
  logic                     re_q, issue;
  logic [CntW-1:0]          in_flight_q, in_flight_d, occupancy;
  logic                     credit, push, pop, empty;
  logic [EntryW-1:0]        head;

  // Occupancy is taken before any same-cycle pop, so a pop frees credit one cycle later.
  assign credit = ({1'b0, occupancy} + {1'b0, in_flight_q}) < SumW'(FQ_DEPTH);
  assign push   = IM_dataValid && !redirect && (state_q inside {StFetch, StStall});
  assign pop    = DEC_dataValid && DEC_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    unique case (state_q)
      StBoot, StFlush:  state_d = StFetch;
      StFetch, StStall: state_d = credit ? StFetch : StStall;
      default:          state_d = StBoot;
    endcase
    if (redirect) begin
      state_d = StFlush;
      pc_d    = redirectPC;
    end else if (state_d == StFetch && credit) begin
      issue  = 1'b1;
      addr_d = pc_q;
      pc_d   = pc_q + ADDRESS_WIDTH'(IPC);
    end
    // Guard against a stale response after reset when nothing is outstanding.
    in_flight_d = in_flight_q + CntW'(issue) - CntW'(IM_dataValid && (in_flight_q != '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StBoot;
      pc_q        <= '0;
      addr_q      <= '0;
      re_q        <= 1'b0;
      in_flight_q <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      re_q        <= issue;
      in_flight_q <= in_flight_d;
      rsp_addr_q  <= addr_q;
    end
  end

  fetch_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (push),
    .push_data ({rsp_addr_q, IM_data}),
    .pop       (pop),
    .head_data (head),
    .empty     (empty),
    .count     (occupancy)
  );

  assign IM_address    = addr_q;
  assign IM_readEnable = re_q;
  assign DEC_dataValid = !empty;
  assign DEC_data      = DEC_dataValid ? head[GroupW-1:0] : '0;
  assign DEC_pc        = DEC_dataValid ? head[EntryW-1:GroupW] : '0;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: directed scenarios plus a
// randomized run against a stream-level reference model.
module tb_instruction_fetch_queue;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned NI    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GW    = NI * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] IM_address;
  logic          IM_readEnable;
  logic [GW-1:0] IM_data = '0;
  logic          IM_dataValid = 1'b0;
  logic [GW-1:0] DEC_data;
  logic          DEC_dataValid;
  logic [AW-1:0] DEC_pc;
  logic          DEC_ready = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirectPC = '0;

  int            n_tests = 0;
  int            n_fail = 0;
  logic          prev_re = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  instruction_fetch_queue #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .IPC           (NI),
    .FQ_DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .IM_address    (IM_address),
    .IM_readEnable (IM_readEnable),
    .IM_data       (IM_data),
    .IM_dataValid  (IM_dataValid),
    .DEC_data      (DEC_data),
    .DEC_dataValid (DEC_dataValid),
    .DEC_pc        (DEC_pc),
    .DEC_ready     (DEC_ready),
    .redirect      (redirect),
    .redirectPC    (redirectPC)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Memory returns slot i of the group at address a as the value a+i.
  function automatic logic [GW-1:0] echo(input logic [AW-1:0] a);
    logic [GW-1:0] g;
    for (int i = 0; i < NI; i++) g[i*DW +: DW] = DW'(a) + DW'(i);
    return g;
  endfunction

  // Advance one cycle; the memory answers each request exactly one cycle later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    IM_dataValid = prev_re;
    IM_data      = echo(prev_addr);
    prev_re      = IM_readEnable;
    prev_addr    = IM_address;
  endtask

  // Leaves the bench in cycle 0 (BOOT), reset just released at a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst          = 1'b0;
    DEC_ready    = 1'b0;
    redirect     = 1'b0;
    redirectPC   = '0;
    IM_dataValid = 1'b0;
    IM_data      = '0;
    prev_re      = 1'b0;
    prev_addr    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (IM_readEnable !== 1'b0) begin
      n_fail++; $display("FAIL reset_re: got %0b expected 0", IM_readEnable);
    end
    n_tests++;
    if (IM_address !== '0) begin
      n_fail++; $display("FAIL reset_addr: got %0h expected 0", IM_address);
    end
    n_tests++;
    if (DEC_dataValid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %0b expected 0", DEC_dataValid);
    end
    n_tests++;
    if (DEC_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %0h expected 0", DEC_data);
    end
    n_tests++;
    if (DEC_pc !== '0) begin
      n_fail++; $display("FAIL reset_pc: got %0h expected 0", DEC_pc);
    end
    rst = 1'b1;
  endtask

  task automatic test_stream(input string tag);
    logic [AW-1:0] exp_pc;
    DEC_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      n_tests++;
      if (IM_readEnable !== 1'b1 || IM_address !== AW'(4 * (c - 1))) begin
        n_fail++;
        $display("FAIL %s_req c%0d: got re=%0b addr=%0h expected re=1 addr=%0h",
                 tag, c, IM_readEnable, IM_address, 4 * (c - 1));
      end
      if (c >= 3) begin
        exp_pc = AW'(4 * (c - 3));
        n_tests++;
        if (DEC_dataValid !== 1'b1 || DEC_pc !== exp_pc || DEC_data !== echo(exp_pc)) begin
          n_fail++;
          $display("FAIL %s_dec c%0d: got v=%0b pc=%0h expected v=1 pc=%0h",
                   tag, c, DEC_dataValid, DEC_pc, exp_pc);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n_req = 0;
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      step();
      if (IM_readEnable) begin
        n_tests++;
        if (IM_address !== AW'(4 * n_req)) begin
          n_fail++;
          $display("FAIL bp_addr: got %0h expected %0h", IM_address, 4 * n_req);
        end
        n_req++;
      end
      if (c >= 3) begin
        n_tests++;
        if (DEC_dataValid !== 1'b1 || DEC_pc !== '0) begin
          n_fail++;
          $display("FAIL bp_head c%0d: got v=%0b pc=%0h expected v=1 pc=0",
                   c, DEC_dataValid, DEC_pc);
        end
      end
    end
    n_tests++;
    if (n_req != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d requests expected 4", n_req);
    end
    n_tests++;
    if (IM_readEnable !== 1'b0) begin
      n_fail++; $display("FAIL bp_idle: got re=%0b expected 0", IM_readEnable);
    end
  endtask

  task automatic test_redirect();
    bit seen = 1'b0;
    do_reset();
    repeat (5) step();
    // Three groups queued, the fourth response arriving this cycle.
    redirect   = 1'b1;
    redirectPC = AW'(10'h100);
    step();
    redirect = 1'b0;
    n_tests++;
    if (DEC_dataValid !== 1'b0 || IM_readEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_flush: got v=%0b re=%0b expected v=0 re=0", DEC_dataValid, IM_readEnable);
    end
    step();
    n_tests++;
    if (IM_readEnable !== 1'b1 || IM_address !== AW'(10'h100)) begin
      n_fail++;
      $display("FAIL redir_req: got re=%0b addr=%0h expected re=1 addr=100",
               IM_readEnable, IM_address);
    end
    DEC_ready = 1'b1;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      seen = DEC_dataValid;
    end
    n_tests++;
    if (!seen || DEC_pc !== AW'(10'h100) || DEC_data !== echo(AW'(10'h100))) begin
      n_fail++;
      $display("FAIL redir_first: got v=%0b pc=%0h expected v=1 pc=100", seen, DEC_pc);
    end
  endtask

  task automatic test_double_redirect();
    bit seen = 1'b0;
    do_reset();
    DEC_ready = 1'b1;
    repeat (6) step();
    redirect   = 1'b1;
    redirectPC = AW'(10'h100);
    step();
    redirectPC = AW'(10'h200);
    n_tests++;
    if (DEC_dataValid !== 1'b0) begin
      n_fail++; $display("FAIL dbl_valid: got %0b expected 0", DEC_dataValid);
    end
    step();
    redirect = 1'b0;
    n_tests++;
    if (IM_readEnable !== 1'b0) begin
      n_fail++; $display("FAIL dbl_flush_re: got %0b expected 0", IM_readEnable);
    end
    step();
    n_tests++;
    if (IM_readEnable !== 1'b1 || IM_address !== AW'(10'h200)) begin
      n_fail++;
      $display("FAIL dbl_req: got re=%0b addr=%0h expected re=1 addr=200", IM_readEnable, IM_address);
    end
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      seen = DEC_dataValid;
    end
    n_tests++;
    if (!seen || DEC_pc !== AW'(10'h200)) begin
      n_fail++; $display("FAIL dbl_first: got v=%0b pc=%0h expected v=1 pc=200", seen, DEC_pc);
    end
  endtask

  task automatic test_boot_redirect();
    bit seen = 1'b0;
    do_reset();
    redirect   = 1'b1;
    redirectPC = AW'(10'h040);
    step();
    redirect = 1'b0;
    n_tests++;
    if (IM_readEnable !== 1'b0) begin
      n_fail++; $display("FAIL boot_redir_flush: got re=%0b expected 0", IM_readEnable);
    end
    step();
    n_tests++;
    if (IM_readEnable !== 1'b1 || IM_address !== AW'(10'h040)) begin
      n_fail++;
      $display("FAIL boot_redir_req: got re=%0b addr=%0h expected re=1 addr=40",
               IM_readEnable, IM_address);
    end
    DEC_ready = 1'b1;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      seen = DEC_dataValid;
    end
    n_tests++;
    if (!seen || DEC_pc !== AW'(10'h040)) begin
      n_fail++; $display("FAIL boot_redir_first: got v=%0b pc=%0h expected v=1 pc=40", seen, DEC_pc);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_seq [3];
    int n_req = 0;
    int n_pop = 0;
    exp_seq = '{AW'(10'h3F8), AW'(10'h3FC), AW'(10'h000)};
    do_reset();
    DEC_ready = 1'b1;
    repeat (3) step();
    redirect   = 1'b1;
    redirectPC = AW'(10'h3F8);
    step();
    redirect = 1'b0;
    for (int c = 0; c < 16 && (n_req < 3 || n_pop < 3); c++) begin
      step();
      if (IM_readEnable && n_req < 3) begin
        n_tests++;
        if (IM_address !== exp_seq[n_req]) begin
          n_fail++; $display("FAIL wrap_req%0d: got %0h expected %0h", n_req, IM_address, exp_seq[n_req]);
        end
        n_req++;
      end
      if (DEC_dataValid && n_pop < 3) begin
        n_tests++;
        if (DEC_pc !== exp_seq[n_pop]) begin
          n_fail++; $display("FAIL wrap_pop%0d: got %0h expected %0h", n_pop, DEC_pc, exp_seq[n_pop]);
        end
        n_pop++;
      end
    end
    n_tests++;
    if (n_req < 3 || n_pop < 3) begin
      n_fail++; $display("FAIL wrap_timeout: got req=%0d pop=%0d expected 3 and 3", n_req, n_pop);
    end
  endtask

  // Toggling ready for 200 cycles, then random ready and random redirects.
  task automatic test_toggle_random();
    logic [AW-1:0] exp_req = '0;
    logic [AW-1:0] exp_pop = '0;
    logic [AW-1:0] rpc;
    logic [AW-1:0] prev_pc = '0;
    logic [GW-1:0] prev_data = '0;
    bit            hold = 1'b0;
    bit            rdy, redir;
    int            issued = 0;
    int            popped = 0;
    int            toggle_pops = 0;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step();
      rdy   = (i < 200) ? ((i % 2) == 0) : ($urandom_range(0, 3) != 0);
      redir = (i >= 200) && ($urandom_range(0, 39) == 0);
      rpc   = AW'($urandom);
      DEC_ready  = rdy;
      redirect   = redir;
      redirectPC = rpc;
      if (IM_readEnable) begin
        n_tests++;
        if (IM_address !== exp_req) begin
          n_fail++; $display("FAIL rnd_req i%0d: got %0h expected %0h", i, IM_address, exp_req);
        end
        exp_req = exp_req + AW'(NI);
        issued++;
      end
      n_tests++;
      if (issued - popped > int'(DEPTH)) begin
        n_fail++;
        $display("FAIL rnd_credit i%0d: got %0d outstanding expected <= %0d", i, issued - popped, DEPTH);
      end
      if (hold) begin
        n_tests++;
        if (DEC_dataValid !== 1'b1 || DEC_pc !== prev_pc || DEC_data !== prev_data) begin
          n_fail++;
          $display("FAIL rnd_hold i%0d: got v=%0b pc=%0h expected v=1 pc=%0h",
                   i, DEC_dataValid, DEC_pc, prev_pc);
        end
      end
      if (DEC_dataValid && rdy) begin
        n_tests++;
        if (DEC_pc !== exp_pop || DEC_data !== echo(exp_pop)) begin
          n_fail++; $display("FAIL rnd_pop i%0d: got pc=%0h expected pc=%0h", i, DEC_pc, exp_pop);
        end
        exp_pop = exp_pop + AW'(NI);
        popped++;
        if (i < 200) toggle_pops++;
      end
      hold      = DEC_dataValid && !rdy && !redir;
      prev_pc   = DEC_pc;
      prev_data = DEC_data;
      if (redir) begin
        exp_req = rpc;
        exp_pop = rpc;
        issued  = 0;
        popped  = 0;
      end
      if (i == 199) begin
        n_tests++;
        if (toggle_pops < 90) begin
          n_fail++; $display("FAIL toggle_rate: got %0d pops expected >= 90", toggle_pops);
        end
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_reset_full();
    do_reset();
    repeat (10) step();
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (IM_readEnable !== 1'b0 || IM_address !== '0) begin
      n_fail++;
      $display("FAIL rstfull_im: got re=%0b addr=%0h expected 0 0", IM_readEnable, IM_address);
    end
    n_tests++;
    if (DEC_dataValid !== 1'b0 || DEC_data !== '0 || DEC_pc !== '0) begin
      n_fail++;
      $display("FAIL rstfull_dec: got v=%0b pc=%0h expected 0 0", DEC_dataValid, DEC_pc);
    end
    @(negedge clk);
    do_reset();
    test_stream("rstfull");
  endtask

  initial begin
    test_reset();
    do_reset();
    test_stream("stream");
    test_backpressure();
    test_redirect();
    test_double_redirect();
    test_boot_redirect();
    test_wrap();
    test_toggle_random();
    test_reset_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
